// File: rtl/axi_mm2s_rd_arbiter_if.sv
// Purpose : Bundles the requester, DataMover command/status and issue-tracking
//           signals of axi_mm2s_rd_arbiter into one interface.
// Ports   : req_valid/req_ready/req_addr/req_nburst  - requester side
//           m_axis_mm2s_cmd_*                         - DataMover MM2S command stream
//           s_axis_mm2s_sts_*                         - DataMover MM2S status stream
//           issue_valid/issue_id                      - per-command owner for the stream router
//           outstanding/busy/err                      - in-flight count and health
// Modports: master - the arbiter's view; slave - the environment's view.
interface axi_mm2s_rd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_nburst;

  logic                          m_axis_mm2s_cmd_tvalid;
  logic                          m_axis_mm2s_cmd_tready;
  logic [ADDR_WIDTH+39:0]        m_axis_mm2s_cmd_tdata;

  logic                          s_axis_mm2s_sts_tvalid;
  logic                          s_axis_mm2s_sts_tready;
  logic [7:0]                    s_axis_mm2s_sts_tdata;

  logic                          issue_valid;
  logic [ID_W-1:0]               issue_id;
  logic [3:0]                    outstanding;
  logic                          busy;
  logic                          err;

  modport master (
    input  req_valid, req_addr, req_nburst,
    input  m_axis_mm2s_cmd_tready,
    input  s_axis_mm2s_sts_tvalid, s_axis_mm2s_sts_tdata,
    output req_ready,
    output m_axis_mm2s_cmd_tvalid, m_axis_mm2s_cmd_tdata,
    output s_axis_mm2s_sts_tready,
    output issue_valid, issue_id, outstanding, busy, err
  );

  modport slave (
    output req_valid, req_addr, req_nburst,
    output m_axis_mm2s_cmd_tready,
    output s_axis_mm2s_sts_tvalid, s_axis_mm2s_sts_tdata,
    input  req_ready,
    input  m_axis_mm2s_cmd_tvalid, m_axis_mm2s_cmd_tdata,
    input  s_axis_mm2s_sts_tready,
    input  issue_valid, issue_id, outstanding, busy, err
  );
endinterface

// File: rtl/axi_mm2s_rd_arbiter.sv
// Purpose : Shares one DataMover MM2S command channel between NUM_REQ read
//           requesters. A round-robin grant accepts one request of N bursts,
//           which is then issued as N commands of BTT bytes each. In-flight
//           commands are counted against returned status words and capped at
//           MAX_OUTSTANDING.
// Ports   : clk  - clock
//           rstn - asynchronous active-low reset
//           bus  - axi_mm2s_rd_arbiter_if.master (requesters, command/status
//                  streams, issue tracking, outstanding/busy/err)
module axi_mm2s_rd_arbiter #(
  parameter int NUM_REQ              = 4,
  parameter int ADDR_WIDTH           = 32,
  parameter int READ_BURST_LEN       = 8,
  parameter int C_S_AXIS_TDATA_WIDTH = 128,
  parameter int LEN_WIDTH            = 8,
  parameter int MAX_OUTSTANDING      = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  axi_mm2s_rd_arbiter_if.master  bus
);

  localparam int BTT  = READ_BURST_LEN * C_S_AXIS_TDATA_WIDTH / 8;
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state_q;
  logic [ID_W-1:0]        rrPtr_q;
  logic [ID_W-1:0]        id_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   remaining_q;
  logic [3:0]             outstanding_q, outstanding_d;
  logic                   err_q, err_d;

  logic                   grantValid;
  logic [ID_W-1:0]        grantId;
  logic [ID_W-1:0]        grantNext;
  logic [NUM_REQ-1:0]     reqReady;
  logic                   cmdValid;
  logic                   cmdFire;
  logic                   stsFire;

  // Round-robin search: first valid requester at or after rrPtr_q, wrapping.
  always_comb begin
    int idx;
    grantValid = 1'b0;
    grantId    = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rrPtr_q) + k) % NUM_REQ;
      if (!grantValid && bus.req_valid[idx]) begin
        grantValid = 1'b1;
        grantId    = ID_W'(idx);
      end
    end
  end

  assign grantNext = (grantId == ID_W'(NUM_REQ - 1)) ? '0 : grantId + ID_W'(1);

  always_comb begin
    reqReady = '0;
    if (state_q == IDLE && grantValid) begin
      reqReady[grantId] = 1'b1;
    end
  end

  assign cmdValid = (state_q == ISSUE) && (outstanding_q < 4'(MAX_OUTSTANDING));
  assign cmdFire  = cmdValid && bus.m_axis_mm2s_cmd_tready;
  assign stsFire  = bus.s_axis_mm2s_sts_tvalid;

  // Request sequencing: the accepted request is latched, then walked one
  // BTT-sized command per handshake until its burst count is exhausted.
  // A zero-burst request is accepted but never leaves IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantValid) begin
            addr_q      <= bus.req_addr[grantId*ADDR_WIDTH +: ADDR_WIDTH];
            remaining_q <= bus.req_nburst[grantId*LEN_WIDTH +: LEN_WIDTH];
            id_q        <= grantId;
            rrPtr_q     <= grantNext;
            if (bus.req_nburst[grantId*LEN_WIDTH +: LEN_WIDTH] != '0) begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (cmdFire) begin
            addr_q      <= addr_q + ADDR_WIDTH'(BTT);
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A status with nothing in flight is spurious: the count is not allowed to
  // underflow and the event is flagged as an error instead.
  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    if (stsFire) begin
      if (outstanding_q == 4'd0) begin
        err_d         = 1'b1;
        outstanding_d = outstanding_q + 4'(cmdFire);
      end else begin
        if (!bus.s_axis_mm2s_sts_tdata[7]) begin
          err_d = 1'b1;
        end
        if (!cmdFire) begin
          outstanding_d = outstanding_q - 4'd1;
        end
      end
    end else if (cmdFire) begin
      outstanding_d = outstanding_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign bus.req_ready              = reqReady;
  assign bus.m_axis_mm2s_cmd_tvalid = cmdValid;
  // Word is forced to zero outside ISSUE so the channel is quiet when idle.
  assign bus.m_axis_mm2s_cmd_tdata  = (state_q == ISSUE) ?
      {4'h0, 4'(id_q), addr_q, 1'b0, 1'b1, 6'b0, 1'b1, 23'(BTT)} : '0;
  assign bus.s_axis_mm2s_sts_tready = 1'b1;
  assign bus.issue_valid            = cmdFire;
  assign bus.issue_id               = (state_q == ISSUE) ? id_q : '0;
  assign bus.outstanding            = outstanding_q;
  assign bus.busy                   = (state_q != IDLE) || (outstanding_q != 4'd0);
  assign bus.err                    = err_q;

endmodule

// File: tb/tb_axi_mm2s_rd_arbiter.sv
// Purpose : Self-checking bench for axi_mm2s_rd_arbiter. A reference model
//           keeps a queue of expected command words, an in-flight count and a
//           round-robin pointer; every cycle the DUT outputs are compared
//           against it, followed by directed checks and a random phase.
// Ports   : none (top-level bench).
module tb_axi_mm2s_rd_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int LW   = 8;
  localparam int BTT  = 128;
  localparam int MAXO = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  axi_mm2s_rd_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  axi_mm2s_rd_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .READ_BURST_LEN(8),
    .C_S_AXIS_TDATA_WIDTH(128), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus.master)
  );

  int checks   = 0;
  int failures = 0;

  logic [AW+39:0] expCmds[$];
  int  grantLog[$];
  int  mOut;
  bit  mErr;
  int  mPtr;
  int  hsCount;
  int  issueCount;
  bit  autoSts;

  // Guards against a hung run: report and stop hard.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [AW+39:0] observed,
                             input logic [AW+39:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Expected DataMover command word built from its field definitions.
  function automatic logic [AW+39:0] cmdWord(input logic [AW-1:0] a, input int id);
    logic [3:0] tag;
    tag = 4'(id);
    return {4'h0, tag, a, 8'h40, 1'b1, 23'd128};
  endfunction

  task automatic modelReset();
    expCmds.delete();
    mOut = 0;
    mErr = 1'b0;
    mPtr = 0;
  endtask

  // One clock cycle: inputs are already set at the falling edge, outputs are
  // compared 1 ns later, the model advances as the rising edge would, and
  // granted requesters drop their valid at the next falling edge.
  task automatic applyStimulus();
    int             g;
    bit             expValid;
    bit             hs;
    logic [AW+39:0] expData;
    logic [N-1:0]   expReady;
    logic [AW-1:0]  a;
    int             nb;
    if (autoSts) begin
      bus.s_axis_mm2s_sts_tvalid = (mOut > 0) && ($urandom_range(0, 1) == 1);
      bus.s_axis_mm2s_sts_tdata  = 8'h80;
    end
    #1;
    expValid = (expCmds.size() > 0) && (mOut < MAXO);
    expData  = (expCmds.size() > 0) ? expCmds[0] : '0;
    g = -1;
    if (expCmds.size() == 0) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && bus.req_valid[(mPtr + k) % N]) g = (mPtr + k) % N;
      end
    end
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    hs = expValid && bus.m_axis_mm2s_cmd_tready;

    checkOutput("req_ready", 72'(bus.req_ready), 72'(expReady));
    checkOutput("cmd_tvalid", 72'(bus.m_axis_mm2s_cmd_tvalid), 72'(expValid));
    checkOutput("cmd_tdata", bus.m_axis_mm2s_cmd_tdata, expData);
    checkOutput("issue_valid", 72'(bus.issue_valid), 72'(hs));
    if (hs) checkOutput("issue_id", 72'(bus.issue_id), 72'(expData[AW+35:AW+32]));
    checkOutput("outstanding", 72'(bus.outstanding), 72'(mOut));
    checkOutput("busy", 72'(bus.busy), 72'((expCmds.size() > 0) || (mOut != 0)));
    checkOutput("err", 72'(bus.err), 72'(mErr));
    checkOutput("sts_tready", 72'(bus.s_axis_mm2s_sts_tready), 72'(1));
    if (bus.issue_valid === 1'b1) issueCount++;

    if (hs) begin
      void'(expCmds.pop_front());
      hsCount++;
    end
    if (g >= 0) begin
      grantLog.push_back(g);
      a  = bus.req_addr[g*AW +: AW];
      nb = int'(bus.req_nburst[g*LW +: LW]);
      for (int b = 0; b < nb; b++) expCmds.push_back(cmdWord(a + AW'(b * BTT), g));
      mPtr = (g + 1) % N;
    end
    if (bus.s_axis_mm2s_sts_tvalid) begin
      if (mOut == 0) begin
        mErr = 1'b1;
        mOut += int'(hs);
      end else begin
        mOut += int'(hs) - 1;
        if (!bus.s_axis_mm2s_sts_tdata[7]) mErr = 1'b1;
      end
    end else begin
      mOut += int'(hs);
    end

    @(negedge clk);
    if (g >= 0) bus.req_valid[g] = 1'b0;
    bus.s_axis_mm2s_sts_tvalid = 1'b0;
  endtask

  task automatic setRequest(input int i, input logic [AW-1:0] a, input int nb);
    bus.req_addr[i*AW +: AW]   = a;
    bus.req_nburst[i*LW +: LW] = LW'(nb);
    bus.req_valid[i]           = 1'b1;
  endtask

  // Asynchronous reset taken between clock edges; all outputs must be quiet.
  task automatic doReset();
    bus.req_valid              = '0;
    bus.s_axis_mm2s_sts_tvalid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_req_ready", 72'(bus.req_ready), 72'(0));
    checkOutput("rst_tvalid", 72'(bus.m_axis_mm2s_cmd_tvalid), 72'(0));
    checkOutput("rst_tdata", bus.m_axis_mm2s_cmd_tdata, 72'(0));
    checkOutput("rst_issue_valid", 72'(bus.issue_valid), 72'(0));
    checkOutput("rst_issue_id", 72'(bus.issue_id), 72'(0));
    checkOutput("rst_outstanding", 72'(bus.outstanding), 72'(0));
    checkOutput("rst_busy", 72'(bus.busy), 72'(0));
    checkOutput("rst_err", 72'(bus.err), 72'(0));
    checkOutput("rst_sts_tready", 72'(bus.s_axis_mm2s_sts_tready), 72'(1));
    @(negedge clk);
    rstn = 1'b1;
    modelReset();
  endtask

  task automatic drainAll(input int budget);
    int c;
    c = 0;
    bus.m_axis_mm2s_cmd_tready = 1'b1;
    autoSts = 1'b1;
    while ((expCmds.size() > 0 || mOut > 0 || bus.req_valid != '0) && c < budget) begin
      applyStimulus();
      c++;
    end
    checkOutput("drain_done", 72'(c < budget), 72'(1));
  endtask

  initial begin
    int expOrder[6];
    expOrder = '{0, 1, 2, 0, 1, 2};
    bus.req_valid              = '0;
    bus.req_addr               = '0;
    bus.req_nburst             = '0;
    bus.m_axis_mm2s_cmd_tready = 1'b0;
    bus.s_axis_mm2s_sts_tvalid = 1'b0;
    bus.s_axis_mm2s_sts_tdata  = '0;
    autoSts = 1'b0;
    modelReset();
    @(negedge clk);
    doReset();

    $display("[TB] three-burst request with status return");
    bus.m_axis_mm2s_cmd_tready = 1'b1;
    hsCount = 0;
    setRequest(0, 32'h0000_1000, 3);
    repeat (4) applyStimulus();
    checkOutput("t1_cmd_count", 72'(hsCount), 72'(3));
    repeat (3) begin
      bus.s_axis_mm2s_sts_tvalid = 1'b1;
      bus.s_axis_mm2s_sts_tdata  = 8'h80;
      applyStimulus();
    end
    applyStimulus();
    checkOutput("t1_outstanding_zero", 72'(bus.outstanding), 72'(0));

    $display("[TB] round-robin order");
    doReset();
    grantLog.delete();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) setRequest(i, 32'h2000 + 32'(i * 'h100), 1);
      drainAll(200);
    end
    checkOutput("t2_grant_count", 72'(grantLog.size()), 72'(6));
    for (int i = 0; i < 6 && i < grantLog.size(); i++)
      checkOutput("t2_grant_order", 72'(grantLog[i]), 72'(expOrder[i]));

    $display("[TB] outstanding cap");
    autoSts = 1'b0;
    bus.m_axis_mm2s_cmd_tready = 1'b1;
    hsCount = 0;
    setRequest(3, 32'h0000_4000, 8);
    repeat (10) applyStimulus();
    checkOutput("t3_capped_count", 72'(hsCount), 72'(4));
    checkOutput("t3_capped_tvalid", 72'(bus.m_axis_mm2s_cmd_tvalid), 72'(0));
    bus.s_axis_mm2s_sts_tvalid = 1'b1;
    bus.s_axis_mm2s_sts_tdata  = 8'h80;
    applyStimulus();
    applyStimulus();
    checkOutput("t3_fifth_cmd", 72'(hsCount), 72'(5));
    drainAll(300);

    $display("[TB] stalled command channel");
    autoSts = 1'b0;
    bus.m_axis_mm2s_cmd_tready = 1'b0;
    issueCount = 0;
    setRequest(1, 32'h0000_5000, 1);
    repeat (6) applyStimulus();
    bus.m_axis_mm2s_cmd_tready = 1'b1;
    applyStimulus();
    checkOutput("t4_single_issue", 72'(issueCount), 72'(1));
    drainAll(100);

    $display("[TB] error status and spurious status");
    autoSts = 1'b0;
    bus.m_axis_mm2s_cmd_tready = 1'b1;
    setRequest(2, 32'h0000_6000, 1);
    repeat (2) applyStimulus();
    bus.s_axis_mm2s_sts_tvalid = 1'b1;
    bus.s_axis_mm2s_sts_tdata  = 8'h40;
    applyStimulus();
    checkOutput("t5_err_slverr", 72'(bus.err), 72'(1));
    bus.s_axis_mm2s_sts_tvalid = 1'b1;
    bus.s_axis_mm2s_sts_tdata  = 8'h80;
    applyStimulus();
    applyStimulus();
    checkOutput("t5_err_sticky", 72'(bus.err), 72'(1));
    checkOutput("t5_no_underflow", 72'(bus.outstanding), 72'(0));

    $display("[TB] address wrap and reset mid-burst");
    doReset();
    bus.m_axis_mm2s_cmd_tready = 1'b1;
    autoSts = 1'b0;
    setRequest(0, 32'hFFFF_FF80, 2);
    repeat (3) applyStimulus();
    setRequest(1, 32'h0000_8000, 6);
    repeat (3) applyStimulus();
    checkOutput("t6_busy_before_reset", 72'(bus.busy), 72'(1));
    doReset();
    applyStimulus();

    $display("[TB] random traffic");
    autoSts = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
          setRequest(i, 32'($urandom), int'($urandom_range(0, 5)));
      end
      repeat ($urandom_range(1, 6)) begin
        bus.m_axis_mm2s_cmd_tready = 1'($urandom_range(0, 1));
        applyStimulus();
      end
    end
    drainAll(600);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
